// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the two-requester add/sub arbiter: FSM state
// encoding, default widths and the operation-select codes of add_sub.
package addsub_arbiter_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int OP_W_DEF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Operation select: 0 add, 1 subtract, 2 reverse subtract, 3 negated sum.
    localparam logic [1:0] FLAG_ADD  = 2'd0;
    localparam logic [1:0] FLAG_SUB  = 2'd1;
    localparam logic [1:0] FLAG_RSUB = 2'd2;
    localparam logic [1:0] FLAG_NEG  = 2'd3;

endpackage

// File: rtl/addsub_arbiter_add_sub.sv
// Shared combinational datapath. All results wrap modulo 2**DATA_W:
//   flag 0: in1 + in2     flag 1: in1 - in2
//   flag 2: in2 - in1     flag 3: -(in1 + in2)
module add_sub
    import addsub_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [OP_W-1:0]   flag,
    output logic [DATA_W-1:0] out
);

    logic [DATA_W-1:0] sum_s;

    assign sum_s = in1 + in2;

    // Select the arithmetic result for the requested operation.
    always_comb begin
        out = {DATA_W{1'b0}};
        case (flag)
            OP_W'(FLAG_ADD):  out = sum_s;
            OP_W'(FLAG_SUB):  out = in1 - in2;
            OP_W'(FLAG_RSUB): out = in2 - in1;
            OP_W'(FLAG_NEG):  out = {DATA_W{1'b0}} - sum_s;
            default:          out = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester arbiter in front of one shared add_sub. One operation is in
// flight at a time: IDLE accepts, EXEC computes, RESP holds the result until
// the granted requester takes it. Ties go to the priority pointer, which
// flips to the other requester after every completed response.
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_in1,
    input  logic [DATA_W-1:0] req0_in2,
    input  logic [OP_W-1:0]   req0_flag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_in1,
    input  logic [DATA_W-1:0] req1_in2,
    input  logic [OP_W-1:0]   req1_flag,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp_out,
    output logic              busy
);

    state_t            state_r;
    state_t            next_state_s;
    logic              prio_r;
    logic              grant_r;
    logic [DATA_W-1:0] op1_r;
    logic [DATA_W-1:0] op2_r;
    logic [OP_W-1:0]   flag_r;
    logic [DATA_W-1:0] result_r;
    logic [DATA_W-1:0] alu_out_s;
    logic              sel_s;
    logic              accept_s;
    logic              resp_done_s;

    add_sub #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_add_sub (
        .in1  (op1_r),
        .in2  (op2_r),
        .flag (flag_r),
        .out  (alu_out_s)
    );

    // Pick the requester to serve: the only valid one, or prio on a tie.
    always_comb begin
        sel_s = 1'b0;
        if (req0_valid && req1_valid) begin
            sel_s = prio_r;
        end else if (req1_valid) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
    end

    assign accept_s    = (state_r == ST_IDLE) && (sel_s ? req1_valid : req0_valid);
    assign resp_done_s = (state_r == ST_RESP) && (grant_r ? resp1_ready : resp0_ready);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: accept -> one compute cycle -> hold until consumed.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EXEC: next_state_s = ST_RESP;
            ST_RESP: begin
                if (resp_done_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state and grant.
    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        busy        = 1'b1;
        case (state_r)
            ST_IDLE: begin
                req0_ready = req0_valid && !sel_s;
                req1_ready = req1_valid && sel_s;
                busy       = 1'b0;
            end
            ST_EXEC: busy = 1'b1;
            ST_RESP: begin
                resp0_valid = !grant_r;
                resp1_valid = grant_r;
            end
            default: busy = 1'b0;
        endcase
    end

    // Operand capture, result capture and priority rotation.
    always_ff @(posedge clk) begin
        if (rst) begin
            op1_r    <= {DATA_W{1'b0}};
            op2_r    <= {DATA_W{1'b0}};
            flag_r   <= {OP_W{1'b0}};
            grant_r  <= 1'b0;
            result_r <= {DATA_W{1'b0}};
            prio_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                op1_r   <= sel_s ? req1_in1 : req0_in1;
                op2_r   <= sel_s ? req1_in2 : req0_in2;
                flag_r  <= sel_s ? req1_flag : req0_flag;
                grant_r <= sel_s;
            end
            if (state_r == ST_EXEC) begin
                result_r <= alu_out_s;
            end
            if (resp_done_s) begin
                prio_r <= ~grant_r;
            end
        end
    end

    assign resp_out = result_r;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a transaction-level reference model
// checked every cycle plus literal expectations for the key scenarios.
module tb_addsub_arbiter;

    localparam int DW = 64;
    localparam int OW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic [OW-1:0] req0_flag, req1_flag;
    logic          resp0_valid, resp1_valid;
    logic          resp0_ready, resp1_ready;
    logic [DW-1:0] resp_out;
    logic          busy;

    logic [DW-1:0] sa_in1, sa_in2, sa_out;
    logic [OW-1:0] sa_flag;

    int total = 0;
    int bad   = 0;

    logic          last_r0, last_r1, last_v0, last_v1, last_busy;
    logic [DW-1:0] last_out;

    // Reference model state: who owns the datapath and how long.
    int            m_owner = -1;
    int            m_age   = 0;
    logic [DW-1:0] m_res   = '0;
    logic          m_prio  = 1'b0;
    logic          m_started = 1'b0;

    addsub_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_flag(req0_flag),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_flag(req1_flag),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_out(resp_out), .busy(busy)
    );

    add_sub #(.DATA_W(DW), .OP_W(OW)) u_sa (
        .in1(sa_in1), .in2(sa_in2), .flag(sa_flag), .out(sa_out)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [OW-1:0] f);
        case (f)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return b - a;
            default: return -(a + b);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model update on each rising edge using the inputs the DUT samples.
    initial forever begin
        @(posedge clk);
        m_started = 1'b1;
        if (rst) begin
            m_owner = -1;
            m_prio  = 1'b0;
        end else if (m_owner < 0) begin
            if (req0_valid && !(req1_valid && m_prio)) begin
                m_owner = 0; m_age = 0; m_res = ref_op(req0_in1, req0_in2, req0_flag);
            end else if (req1_valid) begin
                m_owner = 1; m_age = 0; m_res = ref_op(req1_in1, req1_in2, req1_flag);
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if ((m_owner == 0 && resp0_ready) || (m_owner == 1 && resp1_ready)) begin
            m_prio  = (m_owner == 0);
            m_owner = -1;
        end
    end

    // Compare DUT outputs against the model mid-cycle.
    initial forever begin
        logic e_r0, e_r1, e_v0, e_v1;
        @(negedge clk);
        if (m_started) begin
            e_r0 = (m_owner < 0) && req0_valid && !(req1_valid && m_prio);
            e_r1 = (m_owner < 0) && req1_valid && !(req0_valid && !m_prio);
            e_v0 = (m_owner == 0) && (m_age >= 1);
            e_v1 = (m_owner == 1) && (m_age >= 1);
            chk("m_req0_ready", 64'(req0_ready), 64'(e_r0));
            chk("m_req1_ready", 64'(req1_ready), 64'(e_r1));
            chk("m_resp0_valid", 64'(resp0_valid), 64'(e_v0));
            chk("m_resp1_valid", 64'(resp1_valid), 64'(e_v1));
            chk("m_busy", 64'(busy), 64'(m_owner >= 0));
            if (e_v0 || e_v1) chk("m_resp_out", resp_out, m_res);
        end
    end

    // One clock: sample mid-cycle, drop valids that were accepted.
    task automatic cycle();
        @(negedge clk);
        last_r0 = req0_ready; last_r1 = req1_ready;
        last_v0 = resp0_valid; last_v1 = resp1_valid;
        last_busy = busy; last_out = resp_out;
        @(posedge clk);
        #1;
        if (last_r0) req0_valid = 1'b0;
        if (last_r1) req1_valid = 1'b0;
    endtask

    task automatic wait_resp(input int id, input logic [DW-1:0] exp, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            cycle();
            if ((id == 0 && last_v0) || (id == 1 && last_v1)) begin
                seen = 1'b1;
                chk(nm, last_out, exp);
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s timeout waiting for resp%0d", nm, id);
        end
    endtask

    task automatic set0(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] f);
        req0_in1 = a; req0_in2 = b; req0_flag = f; req0_valid = 1'b1;
    endtask

    task automatic set1(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] f);
        req1_in1 = a; req1_in2 = b; req1_flag = f; req1_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_in1 = '0; req0_in2 = '0; req0_flag = '0;
        req1_in1 = '0; req1_in2 = '0; req1_flag = '0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        sa_in1 = '0; sa_in2 = '0; sa_flag = '0;
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_busy", 64'(last_busy), 64'd0);
        chk("rst_resp0_valid", 64'(last_v0), 64'd0);
        chk("rst_resp1_valid", 64'(last_v1), 64'd0);
        chk("rst_resp_out", last_out, 64'd0);

        // Single request from requester 0.
        set0(64'd10, 64'd5, 2'd0);
        cycle();
        chk("req0_ready_same_cycle", 64'(last_r0), 64'd1);
        wait_resp(0, 64'd15, "req0_add");

        // Single request from requester 1.
        set1(64'd20, 64'd7, 2'd1);
        wait_resp(1, 64'd13, "req1_sub");

        // Simultaneous pairs: alternation driven by the priority pointer.
        set0(64'd100, 64'd200, 2'd0);
        set1(64'd20, 64'd7, 2'd1);
        wait_resp(0, 64'd300, "pair1_first_req0");
        wait_resp(1, 64'd13, "pair1_second_req1");
        set0(64'd1, 64'd2, 2'd0);
        set1(64'd5, 64'd3, 2'd1);
        wait_resp(0, 64'd3, "pair2_first_req0");
        wait_resp(1, 64'd2, "pair2_second_req1");

        // Back-pressure on the response with a competing request waiting.
        resp0_ready = 1'b0;
        set0(64'd7, 64'd3, 2'd1);
        cycle();
        set1(64'd9, 64'd9, 2'd0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("hold_resp0_valid", 64'(last_v0), 64'd1);
            chk("hold_resp_out", last_out, 64'd4);
            chk("hold_req1_ready", 64'(last_r1), 64'd0);
            chk("hold_busy", 64'(last_busy), 64'd1);
        end
        resp0_ready = 1'b1;
        cycle();
        wait_resp(1, 64'd18, "after_hold_req1");

        // Reset while the operation is in EXEC discards it.
        set0(64'd50, 64'd1, 2'd0);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("rst_exec_busy", 64'(last_busy), 64'd0);
        chk("rst_exec_resp0_valid", 64'(last_v0), 64'd0);
        chk("rst_exec_resp_out", last_out, 64'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rst_exec_no_resp", 64'(last_v0 | last_v1), 64'd0);
        end
        set1(64'd5, 64'd6, 2'd0);
        wait_resp(1, 64'd11, "post_rst_op");

        // Flags 2 and 3 with a negative operand, against a standalone add_sub.
        sa_in1 = -64'sd5; sa_in2 = 64'd9; sa_flag = 2'd2;
        set0(-64'sd5, 64'd9, 2'd2);
        wait_resp(0, 64'd14, "flag2_literal");
        chk("flag2_vs_standalone", last_out, sa_out);
        sa_flag = 2'd3;
        set1(-64'sd5, 64'd9, 2'd3);
        wait_resp(1, 64'hFFFF_FFFF_FFFF_FFFC, "flag3_literal");
        chk("flag3_vs_standalone", last_out, sa_out);

        cycle();
        cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
